difftest_step_ctrl: RTL

- Synthesizable, multi-core successor to the simulation-top difftest step/exit logic.
- Collects per-core commit step counts and accumulates them per core.
- Issues check requests one at a time to an external checker (DPI bridge or emulator FIFO) over a valid/ready handshake.
- Sequences init, run, exit, fail and timeout through an explicit FSM, with cycle counting and a max-cycle limit.

---
 rtl/difftest_step_pkg.sv | 21 ++
 rtl/difftest_rr_arbiter.sv | 39 +++
 rtl/difftest_step_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/difftest_step_pkg.sv
// Shared types and constants for the difftest step controller.
package difftest_step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_RUN      = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_EXIT     = 3'd4,
    ST_FAIL     = 3'd5,
    ST_TIMEOUT  = 3'd6
  } state_e;

  localparam logic [7:0] DEFAULT_EXIT_CODE = 8'hFF;
  localparam logic [7:0] RSP_PASS          = 8'h00;

  function automatic int unsigned core_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/difftest_rr_arbiter.sv
// Round-robin picker: first requesting core at or after ptr_i, wrapping to the lowest.
module difftest_rr_arbiter
  import difftest_step_pkg::*;
#(
  parameter  int unsigned NUM_CORES = 1,
  localparam int unsigned IW        = core_idx_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [IW-1:0]        ptr_i,
  output logic [IW-1:0]        winner_o,
  output logic                 any_o
);

  logic          hit_hi;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Two ascending scans replace a modulo walk so non-power-of-two core counts stay simple.
  always_comb begin
    hit_hi = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    any_o  = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (req_i[i]) begin
        if (!hit_hi && (i >= 32'(ptr_i))) begin
          hit_hi = 1'b1;
          hi_idx = IW'(i);
        end
        if (!any_o) begin
          any_o  = 1'b1;
          lo_idx = IW'(i);
        end
      end
    end
    winner_o = hit_hi ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/difftest_step_ctrl.sv
// Multi-core difftest step controller: accumulates commit steps per core and
// sequences init/run/check/exit/fail/timeout against an external checker.
module difftest_step_ctrl
  import difftest_step_pkg::*;
#(
  parameter  int unsigned NUM_CORES   = 1,
  parameter  int unsigned STEP_WIDTH  = 8,
  parameter  int unsigned ACC_WIDTH   = 16,
  parameter  int unsigned CYCLE_WIDTH = 64,
  parameter  logic [7:0]  EXIT_CODE   = DEFAULT_EXIT_CODE,
  localparam int unsigned IW          = core_idx_w(NUM_CORES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
  input  logic [CYCLE_WIDTH-1:0]          max_cycles,
  output logic                            init_valid,
  output logic                            req_valid,
  input  logic                            req_ready,
  output logic [IW-1:0]                   req_core,
  output logic [ACC_WIDTH-1:0]            req_steps,
  input  logic                            rsp_valid,
  input  logic [7:0]                      rsp_code,
  output logic [2:0]                      state,
  output logic                            done,
  output logic                            fail,
  output logic                            timeout,
  output logic                            step_overflow,
  output logic [CYCLE_WIDTH-1:0]          n_cycles,
  output logic [CYCLE_WIDTH-1:0]          fail_cycle
);

  state_e                 state_q, state_d;
  logic [STEP_WIDTH-1:0]  step_q [NUM_CORES];
  logic [ACC_WIDTH-1:0]   acc_q  [NUM_CORES];
  logic [ACC_WIDTH-1:0]   acc_d  [NUM_CORES];
  logic [IW-1:0]          ptr_q, ptr_d;
  logic                   hold_q, hold_d;
  logic [IW-1:0]          hold_core_q, hold_core_d;
  logic [ACC_WIDTH-1:0]   hold_steps_q, hold_steps_d;
  logic                   ovf_q, ovf_d;
  logic [CYCLE_WIDTH-1:0] ncyc_q, ncyc_d;
  logic [CYCLE_WIDTH-1:0] fcyc_q, fcyc_d;
  logic [NUM_CORES-1:0]   nz;
  logic [IW-1:0]          rr_winner;
  logic                   rr_any;
  logic                   active, tmo, hs;
  logic [ACC_WIDTH:0]     sum;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) nz[i] = (acc_q[i] != '0);
  end

  difftest_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .req_i    (nz),
    .ptr_i    (ptr_q),
    .winner_o (rr_winner),
    .any_o    (rr_any)
  );

  assign active = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_WAIT_RSP);
  assign tmo    = ((state_q == ST_RUN) || (state_q == ST_WAIT_RSP)) &&
                  (max_cycles != '0) && (ncyc_q >= max_cycles);
  assign hs     = req_valid && req_ready;

  assign state         = state_q;
  assign done          = (state_q == ST_EXIT);
  assign fail          = (state_q == ST_FAIL);
  assign timeout       = (state_q == ST_TIMEOUT);
  assign step_overflow = ovf_q;
  assign n_cycles      = ncyc_q;
  assign fail_cycle    = fcyc_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    hold_core_d  = hold_core_q;
    hold_steps_d = hold_steps_q;
    fcyc_d       = fcyc_q;
    ncyc_d       = active ? ncyc_q + 1'b1 : ncyc_q;
    init_valid   = 1'b0;
    req_valid    = 1'b0;
    req_core     = '0;
    req_steps    = '0;
    unique case (state_q)
      ST_IDLE: state_d = ST_INIT;
      ST_INIT: begin
        init_valid = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        // A stalled request keeps its captured core/count while the accumulator grows.
        req_valid = !tmo && (hold_q || rr_any);
        if (req_valid) begin
          req_core  = hold_q ? hold_core_q  : rr_winner;
          req_steps = hold_q ? hold_steps_q : acc_q[rr_winner];
        end
        if (tmo) begin
          state_d = ST_TIMEOUT;
          hold_d  = 1'b0;
        end else if (req_valid && req_ready) begin
          state_d = ST_WAIT_RSP;
          hold_d  = 1'b0;
          ptr_d   = (req_core == IW'(NUM_CORES - 1)) ? '0 : req_core + 1'b1;
        end else if (req_valid) begin
          hold_d       = 1'b1;
          hold_core_d  = req_core;
          hold_steps_d = req_steps;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid && (rsp_code != RSP_PASS) && (rsp_code != EXIT_CODE)) begin
          state_d = ST_FAIL;
          fcyc_d  = ncyc_q;
        end else if (rsp_valid && (rsp_code == EXIT_CODE)) begin
          state_d = ST_EXIT;
        end else if (tmo) begin
          state_d = ST_TIMEOUT;
        end else if (rsp_valid) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Add and subtract land together; saturation judges the combined result.
  always_comb begin
    ovf_d = ovf_q;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      sum = {1'b0, acc_q[i]} + (ACC_WIDTH+1)'(step_q[i]);
      if (hs && (req_core == IW'(i))) sum = sum - {1'b0, req_steps};
      if (!active) sum = {1'b0, acc_q[i]};
      if (sum[ACC_WIDTH]) begin
        acc_d[i] = '1;
        ovf_d    = 1'b1;
      end else begin
        acc_d[i] = sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      hold_q       <= 1'b0;
      hold_core_q  <= '0;
      hold_steps_q <= '0;
      ovf_q        <= 1'b0;
      ncyc_q       <= '0;
      fcyc_q       <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        step_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      hold_core_q  <= hold_core_d;
      hold_steps_q <= hold_steps_d;
      ovf_q        <= ovf_d;
      ncyc_q       <= ncyc_d;
      fcyc_q       <= fcyc_d;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        step_q[i] <= core_step[i*STEP_WIDTH +: STEP_WIDTH];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

endmodule
